// File: rtl/pin_teclado_pkg.sv
// pin_teclado_pkg: key codes, FSM states and default timeout for the PIN keypad front end
package pin_teclado_pkg;
   localparam logic [3:0] TECLA_BORRAR       = 4'hA;
   localparam logic [3:0] TECLA_ENTER        = 4'hB;
   localparam int         TIMEOUT_CICLOS_DEF = 200;
   typedef enum logic [1:0] {VACIO, PARCIAL, COMPLETO, ENVIO} estado_t;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: registered rising-edge detector producing a one-cycle accept pulse gated by enable
// Ports: i_clk clock, i_rst_n sync active-low reset, i_nivel key-held level,
//        i_habilitar entry enable, o_pulso accept pulse (valid at the edge the level rises)
module detector_flanco (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_nivel,
   input  logic i_habilitar,
   output logic o_pulso
);
   logic r_prev;
   always_ff @(posedge i_clk)
      r_prev <= i_rst_n ? i_nivel : 1'b0;
   // the level history is tracked even while disabled, so a press that starts disabled is never replayed
   assign o_pulso = i_nivel & ~r_prev & i_habilitar;
endmodule

// File: rtl/pin_teclado.sv
// pin_teclado: assembles a 2-digit BCD PIN from keypad presses and strobes it to the gate controller
// Ports: Clk clock, Reset sync active-low reset, Tecla key code, Tecla_valida key-held level,
//        Habilitar entry enable, Pin assembled PIN, enterPin submit strobe,
//        Digitos digits held, Error_tecla invalid-key / premature-ENTER strobe
module pin_teclado
   import pin_teclado_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
   parameter int ANCHO_TIMER    = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Tecla,
   input  logic       Tecla_valida,
   input  logic       Habilitar,
   output logic [7:0] Pin,
   output logic       enterPin,
   output logic [1:0] Digitos,
   output logic       Error_tecla
);
   localparam logic [ANCHO_TIMER-1:0] LIMITE = ANCHO_TIMER'(TIMEOUT_CICLOS - 1);
   estado_t                r_estado;
   logic [ANCHO_TIMER-1:0] r_timer;
   logic                   w_acepta;
   logic                   w_activo;
   detector_flanco u_flanco (
      .i_clk      (Clk),
      .i_rst_n    (Reset),
      .i_nivel    (Tecla_valida),
      .i_habilitar(Habilitar),
      .o_pulso    (w_acepta)
   );
   assign w_activo = (r_estado == PARCIAL) || (r_estado == COMPLETO);
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Pin         <= '0;
         enterPin    <= 1'b0;
         Digitos     <= '0;
         Error_tecla <= 1'b0;
         r_timer     <= '0;
         r_estado    <= VACIO;
      end else begin
         enterPin    <= 1'b0;
         Error_tecla <= 1'b0;
         r_timer     <= '0;
         if (r_estado == ENVIO) begin
            r_estado <= VACIO;
            Digitos  <= '0;
         end else if (!Habilitar) begin
            // losing enable abandons the entry but leaves Pin visible
            if (w_activo) begin
               r_estado <= VACIO;
               Digitos  <= '0;
            end
         end else if (w_acepta) begin
            if (Tecla <= 4'd9) begin
               Pin      <= {Pin[3:0], Tecla};
               r_estado <= (r_estado == VACIO) ? PARCIAL : COMPLETO;
               Digitos  <= (r_estado == VACIO) ? 2'd1 : 2'd2;
            end else if (Tecla == TECLA_BORRAR) begin
               Pin      <= '0;
               Digitos  <= '0;
               r_estado <= VACIO;
            end else if (Tecla == TECLA_ENTER) begin
               if (r_estado == COMPLETO) begin
                  r_estado <= ENVIO;
                  enterPin <= 1'b1;
               end else begin
                  Error_tecla <= 1'b1;
                  Pin         <= '0;
                  Digitos     <= '0;
                  r_estado    <= VACIO;
               end
            end else
               Error_tecla <= 1'b1;
         end else if (w_activo) begin
            // LIMITE is one less because the discarding edge is itself the last counted idle edge
            if (r_timer == LIMITE) begin
               Pin      <= '0;
               Digitos  <= '0;
               r_estado <= VACIO;
            end else
               r_timer <= r_timer + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pin_teclado.sv
// tb_pin_teclado: directed stimulus with a strobe scoreboard for pin_teclado
module tb_pin_teclado;
   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] Tecla = '0;
   logic       Tecla_valida = 1'b0;
   logic       Habilitar = 1'b1;
   logic [7:0] Pin;
   logic       enterPin;
   logic [1:0] Digitos;
   logic       Error_tecla;
   int compared = 0;
   int mismatched = 0;
   typedef struct {
      bit         ent;
      logic [7:0] pin;
      logic [1:0] dig;
   } exp_t;
   exp_t q[$];
   pin_teclado #(.TIMEOUT_CICLOS(20), .ANCHO_TIMER(8)) dut (
      .Clk(Clk), .Reset(Reset), .Tecla(Tecla), .Tecla_valida(Tecla_valida),
      .Habilitar(Habilitar), .Pin(Pin), .enterPin(enterPin), .Digitos(Digitos),
      .Error_tecla(Error_tecla)
   );
   always #5 Clk = ~Clk;
   // strobe monitor: every enterPin / Error_tecla pulse must match the next queued expectation
   logic prev_e = 1'b0, prev_r = 1'b0;
   always @(negedge Clk) begin
      exp_t e;
      if (enterPin && Error_tecla) begin
         compared++; mismatched++;
         $display("FAIL both_strobes: enterPin=1 Error_tecla=1 required not both");
      end
      if ((enterPin && prev_e) || (Error_tecla && prev_r)) begin
         compared++; mismatched++;
         $display("FAIL strobe_width: strobe high two cycles");
      end
      if (enterPin || Error_tecla) begin
         compared++;
         if (q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_strobe: enterPin=%0b Error_tecla=%0b Pin=%h none expected", enterPin, Error_tecla, Pin);
         end else begin
            e = q.pop_front();
            if (enterPin != e.ent || Pin != e.pin || Digitos != e.dig) begin
               mismatched++;
               $display("FAIL strobe: got enter=%0b Pin=%h Dig=%0d required enter=%0b Pin=%h Dig=%0d",
                        enterPin, Pin, Digitos, e.ent, e.pin, e.dig);
            end
         end
      end
      prev_e = enterPin;
      prev_r = Error_tecla;
   end
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask
   task automatic expect_strobe(input bit ent, input logic [7:0] pin, input logic [1:0] dig);
      exp_t e;
      e.ent = ent; e.pin = pin; e.dig = dig;
      q.push_back(e);
   endtask
   task automatic press(input logic [3:0] k, input int hold);
      Tecla = k;
      Tecla_valida = 1'b1;
      repeat (hold) @(negedge Clk);
      Tecla_valida = 1'b0;
      @(negedge Clk);
   endtask
   task automatic state(input string name, input logic [7:0] pin, input logic [1:0] dig);
      chk({name, "_pin"}, Pin, pin);
      chk({name, "_dig"}, {6'b0, Digitos}, {6'b0, dig});
   endtask
   initial begin
      repeat (2) @(negedge Clk);
      state("reset", 8'h00, 2'd0);
      chk("reset_strobes", {6'b0, enterPin, Error_tecla}, 8'h00);
      Reset = 1'b1;
      @(negedge Clk);
      press(4'h1, 3);  state("k1", 8'h01, 2'd1);
      press(4'h0, 3);  state("k10", 8'h10, 2'd2);
      expect_strobe(1'b1, 8'h10, 2'd2);
      press(4'hB, 3);  state("enter10", 8'h10, 2'd0);
      press(4'h7, 10); state("held7", 8'h07, 2'd1);
      press(4'h3, 3);  state("k73", 8'h73, 2'd2);
      expect_strobe(1'b1, 8'h73, 2'd2);
      press(4'hB, 3);  state("enter73", 8'h73, 2'd0);
      press(4'h5, 3);  state("k5", 8'h35, 2'd1);
      expect_strobe(1'b0, 8'h00, 2'd0);
      press(4'hB, 3);  state("early_enter", 8'h00, 2'd0);
      press(4'h6, 3);  state("k6", 8'h06, 2'd1);
      expect_strobe(1'b0, 8'h06, 2'd1);
      press(4'hE, 3);  state("invalid_E", 8'h06, 2'd1);
      press(4'hA, 3);  state("borrar1", 8'h00, 2'd0);
      press(4'h1, 3);
      press(4'h2, 3);
      press(4'h3, 3);  state("k123", 8'h23, 2'd2);
      expect_strobe(1'b1, 8'h23, 2'd2);
      press(4'hB, 3);
      press(4'h4, 3);  state("k4", 8'h34, 2'd1);
      press(4'hA, 3);  state("borrar2", 8'h00, 2'd0);
      press(4'h9, 1);
      repeat (18) @(negedge Clk);
      state("idle19", 8'h09, 2'd1);
      @(negedge Clk);
      state("timeout", 8'h00, 2'd0);
      expect_strobe(1'b0, 8'h00, 2'd0);
      press(4'hB, 3);
      Habilitar = 1'b0;
      press(4'h1, 3);
      press(4'h0, 3);
      press(4'hB, 3);  state("disabled", 8'h00, 2'd0);
      Habilitar = 1'b1;
      press(4'h1, 3);  state("k1_en", 8'h01, 2'd1);
      Habilitar = 1'b0;
      @(negedge Clk);
      Habilitar = 1'b1;
      state("hab_drop", 8'h01, 2'd0);
      press(4'h1, 3);
      press(4'h0, 3);  state("k10_b", 8'h10, 2'd2);
      Tecla = 4'hB;
      Tecla_valida = 1'b1;
      Reset = 1'b0;
      @(negedge Clk);
      state("reset_enter", 8'h00, 2'd0);
      chk("reset_enter_strobes", {6'b0, enterPin, Error_tecla}, 8'h00);
      Reset = 1'b1;
      Tecla_valida = 1'b0;
      repeat (4) @(negedge Clk);
      chk("queue_drained", 8'(q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pin_teclado.md
Name: pin_teclado

Overview:
- Upstream stage of the parking-gate controller.
- Collects keypad presses and assembles a 2-digit BCD PIN on `Pin[7:0]`. Example: keys 1 then 0 give `8'b0001_0000`.
- Issues a single-cycle `enterPin` strobe to the controller.
- Adds per-press edge qualification, clear/enter keys, invalid-key flagging and an inactivity timeout that discards partial entries.

Parameters:
- TIMEOUT_CICLOS, 200, idle clock cycles with a partial or complete entry before the entry is discarded (minimum 2).
- ANCHO_TIMER, 8, width of the timeout counter; must satisfy 2^ANCHO_TIMER > TIMEOUT_CICLOS.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous reset, active-low (0 at a rising `Clk` edge resets).
- Tecla  input  4  key code: 0x0-0x9 digit, 0xA BORRAR, 0xB ENTER, 0xC-0xF invalid.
- Tecla_valida  input  1  level from keypad scanner; high while a key is held, may last many cycles.
- Habilitar  input  1  from controller (Cerrado | Bloqueo); entry accepted only when 1.
- Pin  output  8  assembled BCD PIN; [7:4] first digit, [3:0] second digit.
- enterPin  output  1  one-cycle strobe: Pin is complete and must be checked.
- Digitos  output  2  digits currently held (0, 1, 2).
- Error_tecla  output  1  one-cycle strobe on invalid key or premature ENTER.

Behaviour:
- Reset (Reset==0 at edge, highest priority over all inputs):
  - Pin=0, enterPin=0, Digitos=0, Error_tecla=0.
  - Timer=0, tecla_prev=0, state VACIO.
- Press acceptance:
  - A press is accepted at an edge where Tecla_valida==1, tecla_prev==0 and Habilitar==1.
  - tecla_prev is the registered Tecla_valida of the previous cycle.
  - A held key is accepted once only. Tecla is sampled at the accepting edge.
  - Edges arriving while Habilitar==0 are dropped and never replayed.
- Latency: every output updates at the accepting edge, i.e. visible one cycle after Tecla_valida rises.
- FSM states: VACIO (Digitos=0), PARCIAL (1), COMPLETO (2), ENVIO.
  - Digit in VACIO/PARCIAL: Pin <= {Pin[3:0], Tecla}; state advances; Digitos increments.
  - Digit in COMPLETO: Pin <= {Pin[3:0], Tecla} (oldest digit discarded); stays COMPLETO, Digitos=2.
  - ENTER in COMPLETO: go to ENVIO; enterPin=1 for exactly that cycle; Pin unchanged.
  - ENVIO -> VACIO unconditionally on the next edge: enterPin=0, Digitos=0, Pin held at submitted value.
  - Any press sampled while in ENVIO is ignored.
  - ENTER in VACIO/PARCIAL: Error_tecla=1 for one cycle; Pin=0, Digitos=0, state VACIO.
  - BORRAR in any state except ENVIO: Pin=0, Digitos=0, state VACIO; no error.
  - Code 0xC-0xF: Error_tecla=1 for one cycle; Pin, Digitos and state unchanged.
- Timeout:
  - Timer counts edges while state is PARCIAL or COMPLETO and no press is accepted.
  - Timer clears on any accepted press and in VACIO/ENVIO.
  - When the count reaches TIMEOUT_CICLOS: Pin=0, Digitos=0, state VACIO, Timer=0, no strobe.
- Habilitar==0 at an edge: if state is PARCIAL or COMPLETO, go to VACIO with Digitos=0 and Timer=0; Pin keeps its value.
  - ENVIO still completes its single cycle regardless of Habilitar.
- Strobes: enterPin and Error_tecla never assert in the same cycle; neither is ever high for two consecutive cycles.

Decomposition:
- Package pin_teclado_pkg:
  - Key codes: TECLA_BORRAR=4'hA, TECLA_ENTER=4'hB.
  - FSM state enum: VACIO, PARCIAL, COMPLETO, ENVIO.
  - Default TIMEOUT_CICLOS.
- Sub-module detector_flanco: registered rising-edge detector with active-low synchronous reset; outputs the 1-cycle accept pulse gated by Habilitar.
- FSM, shifter and timer stay in pin_teclado.

Test Plan:
- Reset low 2 cycles, then keys 1, 0, ENTER (Tecla_valida high 3 cycles each, Habilitar=1):
  - Pin=0x10 after the second key; enterPin high exactly one cycle; then Digitos=0 and Pin stays 0x10.
- Key 7 held high 10 cycles, then key 3, then ENTER: Pin=0x73, Digitos counts 1 then 2 (the held key counts once), one enterPin.
- Key 5, then ENTER: Error_tecla one cycle, enterPin stays 0, Pin=0, Digitos=0. Then key 0xE: Error_tecla pulses, Pin and Digitos unchanged.
- Keys 1, 2, 3, then ENTER: Pin=0x23 at the enterPin pulse. Keys 4, BORRAR: Pin=0, Digitos=0.
- TIMEOUT_CICLOS=20, key 9 then idle 20 cycles: Digitos returns to 0 and Pin=0 on the 20th idle edge; a following ENTER gives Error_tecla.
- Habilitar=0 during keys 1, 0, ENTER: no state change, no strobes. Key 1 with Habilitar=1, then Habilitar low for one cycle: Digitos=0, Pin still 0x01. Reset low coincident with ENTER in COMPLETO: no enterPin, all outputs 0.
